mix_wb_buffer: RTL
==================

Name: mix_wb_buffer

Overview:
- Result buffer directly downstream of the single-cycle mix functional unit.
- Captures each valid mix result (xlen data and transaction ID) into a small in-order FIFO.
- Presents the head entry to the shared writeback arbiter with a valid/ready handshake, so the FU never stalls on a busy writeback port.
- Drives a ready signal back to issue that throttles mix dispatch when the buffer is full.

Parameters:
- DEPTH, 4: number of buffered results; power of two, at least 2.
- XLEN, 32: result data width.
- TRANS_ID_BITS, 3: scoreboard transaction ID width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; discards all buffered and incoming results.
- fu_valid_i  in  1  mix unit result valid this cycle.
- fu_result_i  in  XLEN  mix unit result data.
- fu_trans_id_i  in  TRANS_ID_BITS  mix unit transaction ID.
- fu_ready_o  out  1  buffer can accept a result this cycle; gates mix issue.
- wb_valid_o  out  1  head entry valid toward writeback.
- wb_result_o  out  XLEN  head entry data.
- wb_trans_id_o  out  TRANS_ID_BITS  head entry transaction ID.
- wb_ready_i  in  1  writeback arbiter accepts head this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky error: a result arrived while full.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values, sampled at the edge with rst_i=1: read ptr=0, write ptr=0, count=0, overflow_o=0.
  - Outputs after reset: fu_ready_o=1, wb_valid_o=0, count_o=0.
  - Storage contents are not reset; wb_result_o and wb_trans_id_o are don't-care while wb_valid_o=0.
  - rst_i has priority over every other input, including mid-operation.
- Push:
  - Condition: fu_valid_i & fu_ready_o & !flush_i.
  - Writes {fu_result_i, fu_trans_id_i} at the write pointer; write ptr += 1 mod DEPTH.
- Pop:
  - Condition: wb_valid_o & wb_ready_i & !flush_i.
  - Read ptr += 1 mod DEPTH.
- Derived outputs:
  - fu_ready_o = (count < DEPTH). It is a function of registered state only, with no combinational path from wb_ready_i.
  - wb_valid_o = (count != 0). wb_result_o and wb_trans_id_o come from the entry at the read pointer and are stable while wb_valid_o=1 and wb_ready_i=0.
- Latency: a result pushed in cycle N is visible at the head no earlier than cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO; results leave in arrival order.
- Simultaneous push and pop when not full: both occur; count is unchanged.
- Full (count=DEPTH):
  - fu_ready_o=0.
  - A pop in the same cycle does not enable a push; the push is refused for that cycle.
  - fu_valid_i=1 while fu_ready_o=0: the result is dropped, state is unchanged, and overflow_o sets to 1 at the next edge.
  - overflow_o stays 1 until rst_i; flush_i does not clear it.
- Empty: wb_valid_o=0; wb_ready_i is ignored.
- Flush:
  - Any cycle with flush_i=1 sets read ptr=write ptr=0 and count=0 at the next edge.
  - A concurrent fu_valid_i is discarded and does not set overflow.
  - A concurrent handshake on the wb side is not a completed writeback.
  - Next cycle: wb_valid_o=0 and fu_ready_o=1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided from count, never from pointer equality.
- Invariants (assert in RTL): count ≤ DEPTH; wb_valid_o ⇔ count>0; no push when count=DEPTH.

Test Plan:
- Reset, then three pushes with wb_ready_i=0 (results 0xA, 0xB, 0xC; IDs 1, 2, 3) -> count_o=3, wb_valid_o=1 from cycle after the first push, head=0xA/ID1 held stable.
- Fill to DEPTH=4 with wb_ready_i=0 -> fu_ready_o=0 when count_o=4. Assert fu_valid_i once more with 0xEE -> overflow_o=1 next cycle, 0xEE never appears. Then wb_ready_i=1 drains 4 entries in order.
- Continuous stream: fu_valid_i=1 and wb_ready_i=1 every cycle for 10 cycles, IDs 0..7 then 0..1 -> count_o stays 1 after the first cycle, outputs appear in order one cycle after input, pointers wrap without loss.
- With count_o=2, assert flush_i together with fu_valid_i (0x55) and wb_ready_i=1 -> next cycle count_o=0, wb_valid_o=0, fu_ready_o=1, overflow_o unchanged. 0x55 and the old head are never reported.
- At count_o=4, assert wb_ready_i=1 and fu_valid_i=1 (0x77) in the same cycle -> the pop completes, 0x77 is dropped, overflow_o=1, count_o=3.
- Assert rst_i mid-stream with count_o=3 and overflow_o=1 -> next cycle all outputs at reset values. A subsequent push of 0x99/ID5 appears as head one cycle later.

Source files
------------

// File: rtl/mix_wb_buffer.sv
// In-order result buffer between the mix FU and the shared writeback arbiter.
// Occupancy alone decides full/empty; the pointers simply wrap.
module mix_wb_buffer #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fu_valid_i,
    input  logic [XLEN-1:0]          fu_result_i,
    input  logic [TRANS_ID_BITS-1:0] fu_trans_id_i,
    output logic                     fu_ready_o,
    output logic                     wb_valid_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]          data_q [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q   [DEPTH];

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    assign fu_ready_o    = (count_q != FULL);
    assign wb_valid_o    = (count_q != '0);
    assign wb_result_o   = data_q[rd_q];
    assign wb_trans_id_o = id_q[rd_q];
    assign count_o       = count_q;
    assign overflow_o    = ovf_q;

    assign push = fu_valid_i & fu_ready_o & ~flush_i;
    assign pop  = wb_valid_o & wb_ready_i & ~flush_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
            // A result arriving while full is lost; remember it until reset.
            if (fu_valid_i && !fu_ready_o) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_q] <= fu_result_i;
            id_q[wr_q]   <= fu_trans_id_i;
        end
    end

    a_count_bound: assert property (
        @(posedge clk_i) disable iff (rst_i) count_q <= FULL);
    a_valid_match: assert property (
        @(posedge clk_i) disable iff (rst_i) wb_valid_o == (count_q != '0));
    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(push && count_q == FULL));

endmodule
